anode_scan_ctrl: RTL and testbench



---
 rtl/anode_scan_ctrl_pkg.sv | 31 +++
 rtl/anode_scan_ctrl_next_digit_finder.sv | 20 ++
 rtl/anode_scan_ctrl.sv | 126 ++++++++++++
 tb/tb_anode_scan_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/anode_scan_ctrl_pkg.sv
// Shared types and the circular next-enabled-digit search used by the anode scanner.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    localparam int MAX_DIGITS = 32;

    // Circular search from start+1; walking k downwards lets the nearest hit win.
    // Returns start when no other digit is enabled (or when the mask is empty).
    function automatic int next_enabled(input logic [MAX_DIGITS-1:0] mask,
                                        input int start,
                                        input int num);
        int idx;
        int result;
        result = start;
        for (int k = num; k >= 1; k--) begin
            idx = (start + k) % num;
            if (mask[idx[4:0]]) begin
                result = idx;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/anode_scan_ctrl_next_digit_finder.sv
// Combinational finder: next enabled digit strictly after cur (wrapping) and whether any digit is enabled.
module next_digit_finder
    import scan_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int SEL_W      = $clog2(NUM_DIGITS)
) (
    input  logic [NUM_DIGITS-1:0] mask,
    input  logic [SEL_W-1:0]      cur,
    output logic [SEL_W-1:0]      nxt,
    output logic                  any_enabled
);

    // Priority search is delegated to the package helper so the bench model can share its contract.
    always_comb begin
        nxt         = SEL_W'(next_enabled(MAX_DIGITS'(mask), int'(cur), NUM_DIGITS));
        any_enabled = |mask;
    end

endmodule

// File: rtl/anode_scan_ctrl.sv
// Time-multiplexed anode scanner for common-anode displays: guard blanking, per-digit mask, active-low anodes.
module anode_scan_ctrl
    import scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SEL_W        = $clog2(NUM_DIGITS),
    parameter int PRESCALE     = 100000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NUM_DIGITS-1:0] digit_mask,
    output logic [NUM_DIGITS-1:0] anode_n,
    output logic [SEL_W-1:0]      sel,
    output logic                  scan_tick
);

    localparam int PCW = ($clog2(PRESCALE + 1) < 1) ? 1 : $clog2(PRESCALE + 1);
    localparam int BCW = ($clog2(BLANK_CYCLES + 1) < 1) ? 1 : $clog2(BLANK_CYCLES + 1);
    localparam logic [PCW-1:0] PRE_LAST   = PCW'(PRESCALE - 1);
    localparam logic [BCW-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? BCW'(BLANK_CYCLES - 1) : {BCW{1'b0}};
    // With no guard interval every slot starts directly in DRIVE.
    localparam scan_state_t SLOT_START = (BLANK_CYCLES > 0) ? BLANK : DRIVE;

    scan_state_t     state_r;
    logic [SEL_W-1:0] sel_r;
    logic             tick_r;
    logic [PCW-1:0]   pre_cnt_r;
    logic [BCW-1:0]   blank_cnt_r;

    logic [SEL_W-1:0] next_sel_s;
    logic [SEL_W-1:0] first_sel_s;
    logic             any_s;

    next_digit_finder #(
        .NUM_DIGITS (NUM_DIGITS),
        .SEL_W      (SEL_W)
    ) u_next (
        .mask        (digit_mask),
        .cur         (sel_r),
        .nxt         (next_sel_s),
        .any_enabled (any_s)
    );

    // Lowest enabled index: a circular search that starts just after the top digit.
    always_comb begin
        first_sel_s = SEL_W'(next_enabled(MAX_DIGITS'(digit_mask), NUM_DIGITS - 1, NUM_DIGITS));
    end

    // Scan FSM with prescale/blank counters and registered sel/tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            sel_r       <= {SEL_W{1'b0}};
            tick_r      <= 1'b0;
            pre_cnt_r   <= {PCW{1'b0}};
            blank_cnt_r <= {BCW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (en && any_s) begin
                        sel_r       <= first_sel_s;
                        tick_r      <= 1'b1;
                        state_r     <= SLOT_START;
                        pre_cnt_r   <= {PCW{1'b0}};
                        blank_cnt_r <= {BCW{1'b0}};
                    end else begin
                        tick_r <= 1'b0;
                    end
                end
                BLANK: begin
                    tick_r <= 1'b0;
                    if (!en || !any_s) begin
                        state_r     <= IDLE;
                        pre_cnt_r   <= {PCW{1'b0}};
                        blank_cnt_r <= {BCW{1'b0}};
                    end else if (blank_cnt_r == BLANK_LAST) begin
                        state_r     <= DRIVE;
                        pre_cnt_r   <= {PCW{1'b0}};
                        blank_cnt_r <= {BCW{1'b0}};
                    end else begin
                        blank_cnt_r <= blank_cnt_r + BCW'(1'b1);
                    end
                end
                DRIVE: begin
                    // Losing enable or the whole mask beats a coincident terminal count.
                    if (!en || !any_s) begin
                        state_r     <= IDLE;
                        tick_r      <= 1'b0;
                        pre_cnt_r   <= {PCW{1'b0}};
                        blank_cnt_r <= {BCW{1'b0}};
                    end else if (pre_cnt_r == PRE_LAST) begin
                        sel_r       <= next_sel_s;
                        tick_r      <= 1'b1;
                        state_r     <= SLOT_START;
                        pre_cnt_r   <= {PCW{1'b0}};
                        blank_cnt_r <= {BCW{1'b0}};
                    end else begin
                        tick_r    <= 1'b0;
                        pre_cnt_r <= pre_cnt_r + PCW'(1'b1);
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    tick_r      <= 1'b0;
                    pre_cnt_r   <= {PCW{1'b0}};
                    blank_cnt_r <= {BCW{1'b0}};
                end
            endcase
        end
    end

    // Anode gating stays combinational on the mask so a cleared digit goes dark immediately.
    always_comb begin
        if (state_r == DRIVE) begin
            anode_n = ~(({{(NUM_DIGITS-1){1'b0}}, 1'b1} << sel_r) & digit_mask);
        end else begin
            anode_n = {NUM_DIGITS{1'b1}};
        end
    end

    assign sel       = sel_r;
    assign scan_tick = tick_r;

endmodule

// File: tb/tb_anode_scan_ctrl.sv
// Self-checking bench: two scanner builds (1 and 0 blank cycles) against a slot-timing reference model.
module tb_anode_scan_ctrl;

    localparam int N = 4;
    localparam int P = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] mask;

    logic [3:0] anode_a, anode_b;
    logic [1:0] sel_a, sel_b;
    logic       tick_a, tick_b;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: per instance, whether a scan is running, current digit and position in its slot.
    int m_active [2];
    int m_sel    [2];
    int m_t      [2];
    int blank_of [2] = '{1, 0};

    always #5 clk = ~clk;

    anode_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .en(en), .digit_mask(mask),
        .anode_n(anode_a), .sel(sel_a), .scan_tick(tick_a)
    );

    anode_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .digit_mask(mask),
        .anode_n(anode_b), .sel(sel_b), .scan_tick(tick_b)
    );

    function automatic int lowest_set(input logic [3:0] m);
        for (int i = 0; i < N; i++) begin
            if (m[i]) return i;
        end
        return 0;
    endfunction

    function automatic int next_after(input logic [3:0] m, input int s);
        for (int k = 1; k <= N; k++) begin
            if (m[(s + k) % N]) return (s + k) % N;
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check();
        logic [3:0] ea;
        logic       et;
        for (int i = 0; i < 2; i++) begin
            if (m_active[i] != 0 && m_t[i] >= blank_of[i])
                ea = ~((4'b0001 << m_sel[i]) & mask);
            else
                ea = 4'b1111;
            et = (m_active[i] != 0 && m_t[i] == 0);
            if (i == 0) begin
                chk("b1_anode_n", 32'(anode_a), 32'(ea));
                chk("b1_sel", 32'(sel_a), 32'(m_sel[i]));
                chk("b1_scan_tick", 32'(tick_a), 32'(et));
            end else begin
                chk("b0_anode_n", 32'(anode_b), 32'(ea));
                chk("b0_sel", 32'(sel_b), 32'(m_sel[i]));
                chk("b0_scan_tick", 32'(tick_b), 32'(et));
            end
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_active[i] = 0; m_sel[i] = 0; m_t[i] = 0;
            end else if (m_active[i] == 0) begin
                if (en && mask != 4'b0000) begin
                    m_active[i] = 1; m_sel[i] = lowest_set(mask); m_t[i] = 0;
                end
            end else if (!en || mask == 4'b0000) begin
                m_active[i] = 0; m_t[i] = 0;
            end else begin
                m_t[i]++;
                if (m_t[i] == blank_of[i] + P) begin
                    m_t[i]   = 0;
                    m_sel[i] = next_after(mask, m_sel[i]);
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check();
    endtask

    // Advance until the 1-blank build sits at the given digit and slot position.
    task automatic run_to(input int s, input int t);
        for (int n = 0; n < 60; n++) begin
            if (m_active[0] != 0 && m_sel[0] == s && m_t[0] == t) return;
            step();
        end
        vectors++;
        miscompares++;
        $error("FAIL run_to_timeout observed=sel%0d/t%0d expected=sel%0d/t%0d", m_sel[0], m_t[0], s, t);
    endtask

    initial begin
        m_active = '{0, 0}; m_sel = '{0, 0}; m_t = '{0, 0};
        rst = 1'b1; en = 1'b1; mask = 4'b1111;
        repeat (2) step();
        rst = 1'b0; en = 1'b0;
        repeat (3) step();

        en = 1'b1;
        repeat (24) step();

        mask = 4'b0101;
        repeat (22) step();

        mask = 4'b0100;
        repeat (16) step();

        // Drop enable, then reset, on the second DRIVE cycle of digit 1.
        mask = 4'b1111;
        run_to(1, 2);
        en = 1'b0;
        step();
        en = 1'b1;
        repeat (6) step();
        run_to(1, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (6) step();

        // Clear the lit digit's mask bit mid-slot; darkness must be immediate.
        run_to(1, 2);
        mask = 4'b1101;
        #1;
        check();
        repeat (10) step();
        mask = 4'b0000;
        repeat (8) step();

        rst = 1'b1;
        step();
        rst = 1'b0; mask = 4'b1111;
        repeat (20) step();

        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            en  = ($urandom_range(0, 11) != 0);
            if ($urandom_range(0, 7) == 0) mask = 4'($urandom_range(0, 15));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
